multicycle_shifter: RTL and testbench
=====================================

# multicycle_shifter

Iterative one-bit-per-cycle shifter for the KGP-RISC execute stage; consumes the 32-bit zero-extended shift amount produced by the 6-to-32 leading-zero padder (immediate shifts) or a 32-bit register value (variable shifts). Handles logical left, logical right and arithmetic right shifts with a start/busy/done handshake, so the ALU path stays free of a 32-bit barrel shifter. Result is held stable until the next accepted start.

## Interface
- No parameters; data width fixed at 32, counter width fixed at 6.
- `clk` input 1: single system clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `busy` is low.
- `op` input 2: 00 = sll, 01 = srl, 10 = sra, 11 = reserved.
- `operand` input 32: value to shift; sampled with `start`.
- `amount` input 32: shift count, unsigned; sampled with `start`.
- `busy` output 1: high while an operation is in progress (SHIFT or DONE state).
- `done` output 1: one-cycle pulse when `result` becomes valid.
- `result` output 32: shifted value; held until the next accepted start.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `start`=1 -> latch `operand` into working register, latch `op`, load counter with effective count N; go to SHIFT if N>0, else to DONE.
- Effective count: N = 32 if `amount` > 32 (any of bits 31:6 set, or bits 5:0 > 32), else N = `amount`[5:0]. Range 0..32.
- SHIFT: each cycle shift working register by one bit and decrement counter; on the cycle where the counter goes 1 -> 0, go to DONE.
  - sll: shift left, fill 0. srl: shift right, fill 0. sra: shift right, fill with bit 31 of the working register.
  - reserved op 11: treated as N = 0 (working register unchanged), no error flag.
- DONE: `done`=1, `result` = working register; next state IDLE unconditionally.
- `result` is updated only on entering DONE; between operations it keeps the last value.
- Saturation semantics: sll/srl by >= 32 give 0x0000_0000; sra by >= 32 gives 0x0000_0000 or 0xFFFF_FFFF per the sign of `operand`.
- `start` while `busy`=1: ignored; no latching, no queueing.
- `start` asserted in the same cycle the block returns to IDLE (cycle after DONE): accepted normally.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0x0000_0000, counter 0, working register 0.
- `rst` has priority over `start` and aborts any operation in SHIFT or DONE; no `done` pulse for the aborted operation.
- Start accepted at edge k -> `busy` high from cycle k+1 through cycle k+N+1; `done` high in cycle k+N+1 only.
- N=0: `done` in cycle k+1 (latency 1). N=32: `done` in cycle k+33.
- Back-to-back throughput: one operation per N+2 cycles.
- Outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package `kgp_shift_pkg`: op encodings (`OP_SLL`, `OP_SRL`, `OP_SRA`), state enum (IDLE/SHIFT/DONE), `SHIFT_MAX` = 32.
- One combinational sub-module `shift_step`: inputs 32-bit value and op, output the one-bit-shifted value; instantiated once in the datapath.
- Effective-count saturation and FSM live in the top module.

## Test plan
- sll, `operand`=0x0000_0001, `amount`=4 -> `done` 5 cycles after start edge, `result`=0x0000_0010, `busy` high 5 cycles.
- sra, `operand`=0x8000_0000, `amount`=31 -> `result`=0xFFFF_FFFF at cycle k+32; srl same inputs -> 0x0000_0001.
- srl, `operand`=0xDEAD_BEEF, `amount`=0 -> `done` at cycle k+1, `result`=0xDEAD_BEEF; op 11 with `amount`=7 gives same.
- `amount`=0x0000_0040: sra of 0x8000_0001 -> 0xFFFF_FFFF, srl -> 0x0000_0000, sll of 0x7FFF_FFFF -> 0x0000_0000, each at cycle k+33.
- Second `start` (different operand) pulsed mid-SHIFT -> ignored, first result unchanged; `start` in cycle after `done` -> accepted.
- `rst` asserted during SHIFT of an N=10 operation -> next cycle `busy`=0, `result`=0, no `done` pulse.

Source files
------------

// File: rtl/kgp_shift_pkg.sv
// Shared definitions for the iterative shifter: widths, op codes and FSM states.
package kgp_shift_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned SHIFT_MAX = 32;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift of a data word; reserved op passes the value through.
module shift_step
  import kgp_shift_pkg::*;
(
  input  logic [DATA_W-1:0] i_value,
  input  op_e               i_op,
  output logic [DATA_W-1:0] o_value_c
);

  // Select the single-bit shift for the current op
  always_comb begin
    o_value_c = i_value;
    case (i_op)
      OP_SLL:  o_value_c = {i_value[DATA_W-2:0], 1'b0};
      OP_SRL:  o_value_c = {1'b0, i_value[DATA_W-1:1]};
      OP_SRA:  o_value_c = {i_value[DATA_W-1], i_value[DATA_W-1:1]};
      default: o_value_c = i_value;
    endcase
  end

endmodule

// File: rtl/multicycle_shifter.sv
// Iterative one-bit-per-cycle shifter with start/busy/done handshake.
module multicycle_shifter
  import kgp_shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] amount,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  state_e            r_state;
  state_e            w_state_nxt;
  op_e               r_op;
  op_e               w_op_nxt;
  logic [DATA_W-1:0] r_work;
  logic [DATA_W-1:0] w_work_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] w_result_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [DATA_W-1:0] w_step;
  logic              w_amt_sat;
  logic [CNT_W-1:0]  w_eff_cnt;

  shift_step u_shift_step (
    .i_value   (r_work),
    .i_op      (r_op),
    .o_value_c (w_step)
  );

  // Effective count: saturate above SHIFT_MAX; reserved op never shifts
  always_comb begin
    w_amt_sat = (|amount[DATA_W-1:CNT_W]) ||
                (amount[CNT_W-1:0] > CNT_W'(SHIFT_MAX));
    if (op_e'(op) == OP_RSV) begin
      w_eff_cnt = '0;
    end else if (w_amt_sat) begin
      w_eff_cnt = CNT_W'(SHIFT_MAX);
    end else begin
      w_eff_cnt = amount[CNT_W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, datapath next values and registered output next values
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_work_nxt   = r_work;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_work_nxt = operand;
          w_op_nxt   = op_e'(op);
          w_cnt_nxt  = w_eff_cnt;
          if (w_eff_cnt == '0) begin
            w_state_nxt  = ST_DONE;
            w_result_nxt = operand;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        w_work_nxt = w_step;
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = ST_DONE;
          w_result_nxt = w_step;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_SLL;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_op     <= w_op_nxt;
      r_work   <= w_work_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Self-checking bench for multicycle_shifter against a behavioural shift model.
module tb_multicycle_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [31:0] amount;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests;
  int fails;

  multicycle_shifter dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .operand (operand),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Number of single-bit steps the operation takes
  function automatic int ref_n(input logic [1:0] o, input logic [31:0] a);
    if (o == 2'b11) return 0;
    if (a > 32'd32) return 32;
    return int'(a);
  endfunction

  // Result of shifting v by a under op o, saturating at 32 positions
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v,
                                            input logic [31:0] a);
    int n;
    n = ref_n(o, a);
    case (o)
      2'b00:   return (n >= 32) ? 32'h0 : (v << n);
      2'b01:   return (n >= 32) ? 32'h0 : (v >> n);
      2'b10:   return (n >= 32) ? {32{v[31]}} : 32'($signed(v) >>> n);
      default: return v;
    endcase
  endfunction

  // Issue one operation from an idle negedge; optionally pulse start at cycle intrude.
  // Returns at the negedge of the first idle cycle after done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                        input logic [31:0] a, input int intrude);
    int          n;
    int          lat;
    bit          seen;
    logic [31:0] exp;
    n   = ref_n(o, a);
    exp = ref_shift(o, v, a);
    start = 1'b1; op = o; operand = v; amount = a;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); operand = $urandom; amount = $urandom;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      lat = c;
      check({tag, ".busy_run"}, 32'(busy), 32'd1);
      if (done === 1'b1) seen = 1'b1;
      start = (c == intrude);
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(n + 1));
    check({tag, ".result"}, result, exp);
    @(negedge clk);
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    check({tag, ".done_low"}, 32'(done), 32'd0);
    check({tag, ".result_hold"}, result, exp);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    logic [1:0]  ro;
    logic [31:0] rv;
    logic [31:0] ra;
    tests = 0;
    fails = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; operand = 32'h0; amount = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", result, 32'h0);
    @(negedge clk);

    // Directed cases from the plan, issued back to back
    run_op("sll_1_by_4",    2'b00, 32'h0000_0001, 32'd4,  0);
    run_op("sra_msb_by_31", 2'b10, 32'h8000_0000, 32'd31, 0);
    run_op("srl_msb_by_31", 2'b01, 32'h8000_0000, 32'd31, 0);
    run_op("srl_by_0",      2'b01, 32'hDEAD_BEEF, 32'd0,  0);
    run_op("rsv_by_7",      2'b11, 32'hDEAD_BEEF, 32'd7,  0);
    run_op("sra_by_64",     2'b10, 32'h8000_0001, 32'h40, 0);
    run_op("srl_by_64",     2'b01, 32'h8000_0001, 32'h40, 0);
    run_op("sll_by_64",     2'b00, 32'h7FFF_FFFF, 32'h40, 0);
    run_op("sll_by_32",     2'b00, 32'hFFFF_FFFF, 32'd32, 0);
    run_op("sra_pos_by_33", 2'b10, 32'h7FFF_FFFF, 32'd33, 0);
    run_op("sra_by_hi_bit", 2'b10, 32'h8000_0000, 32'h8000_0001, 0);

    // Start pulsed mid-shift must be ignored
    run_op("ignore_start",  2'b00, 32'h0000_0003, 32'd10, 3);
    run_op("after_ignore",  2'b01, 32'hF000_0000, 32'd5,  0);

    // Reset during SHIFT aborts the operation without a done pulse
    start = 1'b1; op = 2'b00; operand = 32'h0000_0005; amount = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", result, 32'h0);
    done_cnt = 0;
    busy_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    check("abort.no_done", 32'(done_cnt), 32'd0);
    check("abort.no_busy", 32'(busy_cnt), 32'd0);

    // Randomized operations, back to back
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rv = $urandom;
      case ($urandom_range(0, 3))
        0:       ra = 32'($urandom_range(0, 33));
        1:       ra = $urandom;
        2:       ra = 32'd32;
        default: ra = 32'($urandom_range(0, 63));
      endcase
      run_op($sformatf("rand%0d", i), ro, rv, ra, (i % 5 == 0) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
